// File: rtl/dom_sbox_pipe.sv
// dom_sbox_pipe: SHARES-share DOM-masked S-AES S-box (fwd/inv) using
// GF((2^2)^2) tower inversion, three register stages, valid/ready flow.
module dom_sbox_pipe #(
  parameter int SHARES = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_inv,
  input  logic [4*SHARES-1:0]                in_shares,
  input  logic [6*(SHARES*(SHARES-1)/2)-1:0] rnd,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [4*SHARES-1:0]                out_shares
);

  localparam int R     = SHARES * (SHARES - 1) / 2;
  localparam int RND_W = 6 * R;

  if (SHARES < 2 || SHARES > 4) begin : g_bad_shares
    $error("dom_sbox_pipe: SHARES must be 2..4");
  end

  // GF(4) = GF(2)[y]/(y^2+y+1); tower GF(16) = GF(4)[z]/(z^2+z+y)
  function automatic logic [1:0] gf4_mul(logic [1:0] a, logic [1:0] b);
    logic [1:0] p;
    p[1] = (a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]);
    p[0] = (a[1] & b[1]) ^ (a[0] & b[0]);
    return p;
  endfunction

  function automatic logic [1:0] gf4_sq(logic [1:0] a);
    return {a[1], a[1] ^ a[0]};
  endfunction

  function automatic logic [1:0] gf4_sqn(logic [1:0] a);
    return {a[0], a[1]};
  endfunction

  function automatic logic [3:0] t_mul(logic [3:0] a, logic [3:0] b);
    logic [1:0] hh;
    logic [1:0] hi;
    logic [1:0] lo;
    hh = gf4_mul(a[3:2], b[3:2]);
    hi = hh ^ gf4_mul(a[3:2], b[1:0]) ^ gf4_mul(a[1:0], b[3:2]);
    lo = gf4_mul(hh, 2'b10) ^ gf4_mul(a[1:0], b[1:0]);
    return {hi, lo};
  endfunction

  function automatic logic [3:0] lin(logic [15:0] m, logic [3:0] x);
    logic [3:0] y;
    y = 4'h0;
    for (int i = 0; i < 4; i++)
      if (x[i]) y = y ^ m[4*i +: 4];
    return y;
  endfunction

  // Basis change found at elaboration: x -> root of x^4+x+1 in tower field
  function automatic logic [15:0] iso_fwd();
    logic [3:0]  b;
    logic [3:0]  b2;
    logic [3:0]  b4;
    logic [15:0] m;
    m = '0;
    for (int c = 2; c < 16; c++) begin
      b  = 4'(c);
      b2 = t_mul(b, b);
      b4 = t_mul(b2, b2);
      if ((b4 ^ b ^ 4'h1) == 4'h0 && m == '0)
        m = {t_mul(b2, b), b2, b, 4'h1};
    end
    return m;
  endfunction

  function automatic logic [15:0] inv_mat(logic [15:0] m);
    logic [15:0] r;
    r = '0;
    for (int j = 0; j < 4; j++)
      for (int x = 0; x < 16; x++)
        if (lin(m, 4'(x)) == 4'(1 << j)) r[4*j +: 4] = 4'(x);
    return r;
  endfunction

  function automatic logic [15:0] compose(logic [15:0] a, logic [15:0] b);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      r[4*i +: 4] = lin(a, b[4*i +: 4]);
    return r;
  endfunction

  function automatic int pidx(int i, int j);
    return i * SHARES - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  localparam logic [15:0] AFF     = {4'hE, 4'h7, 4'hB, 4'hD};
  localparam logic [15:0] ISO     = iso_fwd();
  localparam logic [15:0] ISO_INV = inv_mat(ISO);
  localparam logic [15:0] MAP_I   = compose(ISO, inv_mat(AFF));
  localparam logic [15:0] OUT_F   = compose(AFF, ISO_INV);
  localparam logic [3:0]  C_I     = lin(MAP_I, 4'h9);

  function automatic logic [3:0] map_in(logic inv, logic s0, logic [3:0] x);
    logic [3:0] t;
    t = inv ? lin(MAP_I, x) : lin(ISO, x);
    if (inv && s0) t = t ^ C_I;
    return t;
  endfunction

  function automatic logic [3:0] map_out(logic inv, logic s0, logic [3:0] t);
    logic [3:0] y;
    y = inv ? lin(ISO_INV, t) : lin(OUT_F, t);
    if (!inv && s0) y = y ^ 4'h9;
    return y;
  endfunction

  logic en;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic r1_inv_q, r1_inv_d, r2_inv_q, r2_inv_d;
  logic [SHARES-1:0][1:0] s1_a1, s1_a0;
  logic [SHARES-1:0][SHARES-1:0][1:0] s1_c;
  logic [SHARES-1:0][1:0] r1_a1_q, r1_a1_d, r1_a0_q, r1_a0_d;
  logic [SHARES-1:0][SHARES-1:0][1:0] r1_c_q, r1_c_d;
  logic [SHARES-1:0][1:0] s2_d, s2_di;
  logic [SHARES-1:0][1:0] r2_a1_q, r2_a1_d, r2_a0_q, r2_a0_d;
  logic [SHARES-1:0][1:0] r2_di_q, r2_di_d;
  logic [SHARES-1:0][1:0] s3_b1, s3_b0;
  logic [4*SHARES-1:0] s3_out, out_q, out_d;

  // out_ready reaches in_ready combinationally through en
  always_comb begin
    en = !v3_q | out_ready;
  end

  assign in_ready   = en;
  assign out_valid  = v3_q;
  assign out_shares = out_q;

  // Diagonal of s1_c holds each domain's own terms
  always_comb begin
    s1_a1 = '0;
    s1_a0 = '0;
    s1_c  = '0;
    for (int i = 0; i < SHARES; i++) begin
      {s1_a1[i], s1_a0[i]} = map_in(in_inv, i == 0, in_shares[4*i +: 4]);
      s1_c[i][i] = gf4_sqn(s1_a1[i]) ^ gf4_sq(s1_a0[i])
                 ^ gf4_mul(s1_a1[i], s1_a0[i]);
    end
    for (int i = 0; i < SHARES; i++)
      for (int j = i + 1; j < SHARES; j++) begin
        s1_c[i][j] = gf4_mul(s1_a1[i], s1_a0[j]) ^ rnd[2*pidx(i, j) +: 2];
        s1_c[j][i] = gf4_mul(s1_a1[j], s1_a0[i]) ^ rnd[2*pidx(i, j) +: 2];
      end
  end

  always_comb begin
    v1_d     = v1_q;
    r1_inv_d = r1_inv_q;
    r1_a1_d  = r1_a1_q;
    r1_a0_d  = r1_a0_q;
    r1_c_d   = r1_c_q;
    if (en) begin
      v1_d     = in_valid;
      r1_inv_d = in_valid & in_inv;
      r1_a1_d  = in_valid ? s1_a1 : '0;
      r1_a0_d  = in_valid ? s1_a0 : '0;
      r1_c_d   = in_valid ? s1_c : '0;
    end
  end

  always_comb begin
    s2_d  = '0;
    s2_di = '0;
    for (int i = 0; i < SHARES; i++) begin
      for (int j = 0; j < SHARES; j++)
        s2_d[i] = s2_d[i] ^ r1_c_q[i][j];
      s2_di[i] = gf4_sq(s2_d[i]);
    end
  end

  always_comb begin
    v2_d     = v2_q;
    r2_inv_d = r2_inv_q;
    r2_a1_d  = r2_a1_q;
    r2_a0_d  = r2_a0_q;
    r2_di_d  = r2_di_q;
    if (en) begin
      v2_d     = v1_q;
      r2_inv_d = v1_q & r1_inv_q;
      r2_a1_d  = v1_q ? r1_a1_q : '0;
      r2_a0_d  = v1_q ? r1_a0_q : '0;
      r2_di_d  = v1_q ? s2_di : '0;
    end
  end

  always_comb begin
    s3_b1  = '0;
    s3_b0  = '0;
    s3_out = '0;
    for (int i = 0; i < SHARES; i++) begin
      s3_b1[i] = gf4_mul(r2_a1_q[i], r2_di_q[i]);
      s3_b0[i] = gf4_mul(r2_a1_q[i] ^ r2_a0_q[i], r2_di_q[i]);
    end
    for (int i = 0; i < SHARES; i++)
      for (int j = i + 1; j < SHARES; j++) begin
        s3_b1[i] ^= gf4_mul(r2_a1_q[i], r2_di_q[j])
                  ^ rnd[2*R + 2*pidx(i, j) +: 2];
        s3_b1[j] ^= gf4_mul(r2_a1_q[j], r2_di_q[i])
                  ^ rnd[2*R + 2*pidx(i, j) +: 2];
        s3_b0[i] ^= gf4_mul(r2_a1_q[i] ^ r2_a0_q[i], r2_di_q[j])
                  ^ rnd[RND_W - 2*R + 2*pidx(i, j) +: 2];
        s3_b0[j] ^= gf4_mul(r2_a1_q[j] ^ r2_a0_q[j], r2_di_q[i])
                  ^ rnd[RND_W - 2*R + 2*pidx(i, j) +: 2];
      end
    for (int i = 0; i < SHARES; i++)
      s3_out[4*i +: 4] = map_out(r2_inv_q, i == 0, {s3_b1[i], s3_b0[i]});
  end

  always_comb begin
    v3_d  = v3_q;
    out_d = out_q;
    if (en) begin
      v3_d  = v2_q;
      out_d = v2_q ? s3_out : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      r1_inv_q <= 1'b0;
      r2_inv_q <= 1'b0;
      r1_a1_q  <= '0;
      r1_a0_q  <= '0;
      r1_c_q   <= '0;
      r2_a1_q  <= '0;
      r2_a0_q  <= '0;
      r2_di_q  <= '0;
      out_q    <= '0;
    end else begin
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      r1_inv_q <= r1_inv_d;
      r2_inv_q <= r2_inv_d;
      r1_a1_q  <= r1_a1_d;
      r1_a0_q  <= r1_a0_d;
      r1_c_q   <= r1_c_d;
      r2_a1_q  <= r2_a1_d;
      r2_a0_q  <= r2_a0_d;
      r2_di_q  <= r2_di_d;
      out_q    <= out_d;
    end
  end

endmodule

// File: tb/tb_dom_sbox_pipe.sv
// tb_dom_sbox_pipe: drives SHARES=2,3,4 instances in lockstep and checks
// recombined outputs against the S-AES S-box tables.
module tb_dom_sbox_pipe;

  localparam logic [3:0] SBOX [16] = '{4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1,
    4'h8, 4'h5, 4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7};
  localparam logic [3:0] SINV [16] = '{4'hA, 4'h5, 4'h9, 4'hB, 4'h1, 4'h7,
    4'h8, 4'hF, 4'h6, 4'h0, 4'h2, 4'h3, 4'hC, 4'h4, 4'hD, 4'hE};
  localparam logic [3:0] VALS [8] = '{4'h3, 4'h7, 4'hE, 4'h0, 4'h9, 4'h4,
    4'hC, 4'h1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_inv, out_ready;
  logic [7:0]  in2, o2;
  logic [11:0] in3, o3;
  logic [15:0] in4, o4;
  logic [35:0] rnd;
  logic        ir2, ir3, ir4, ov2, ov3, ov4;
  logic [35:0] all_o;
  logic [3:0]  got [3];
  logic        ov [3];
  logic        ir [3];

  logic        use_fix;
  logic [11:0] fix_m;
  logic [1:0]  rmode;
  int          ncmp = 0;
  int          nbad = 0;

  dom_sbox_pipe #(.SHARES(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2),
    .in_inv(in_inv), .in_shares(in2), .rnd(rnd[5:0]),
    .out_valid(ov2), .out_ready(out_ready), .out_shares(o2));

  dom_sbox_pipe #(.SHARES(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir3),
    .in_inv(in_inv), .in_shares(in3), .rnd(rnd[17:0]),
    .out_valid(ov3), .out_ready(out_ready), .out_shares(o3));

  dom_sbox_pipe #(.SHARES(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4),
    .in_inv(in_inv), .in_shares(in4), .rnd(rnd),
    .out_valid(ov4), .out_ready(out_ready), .out_shares(o4));

  assign all_o  = {o4, o3, o2};
  assign got[0] = o2[7:4] ^ o2[3:0];
  assign got[1] = o3[11:8] ^ o3[7:4] ^ o3[3:0];
  assign got[2] = o4[15:12] ^ o4[11:8] ^ o4[7:4] ^ o4[3:0];
  assign ov[0]  = ov2;
  assign ov[1]  = ov3;
  assign ov[2]  = ov4;
  assign ir[0]  = ir2;
  assign ir[1]  = ir3;
  assign ir[2]  = ir4;

  task automatic drive(input logic v, input logic [3:0] x,
                       input logic inv, input logic ordy);
    logic [3:0] m1, m2, m3;
    @(posedge clk);
    #1;
    if (use_fix) {m3, m2, m1} = fix_m;
    else {m3, m2, m1} = 12'($urandom);
    in_valid  = v;
    in_inv    = inv;
    out_ready = ordy;
    in2 = {m1, x ^ m1};
    in3 = {m2, m1, x ^ m1 ^ m2};
    in4 = {m3, m2, m1, x ^ m1 ^ m2 ^ m3};
    case (rmode)
      2'd1:    rnd = '0;
      2'd2:    rnd = '1;
      default: rnd = {4'($urandom), $urandom};
    endcase
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      ncmp++;
      if (ov[k] !== 1'b0) begin
        nbad++;
        $display("FAIL rst_valid s%0d: got %b want 0", k + 2, ov[k]);
      end
    end
    ncmp++;
    if (all_o !== 36'h0) begin
      nbad++;
      $display("FAIL rst_shares: got %h want 0", all_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      ncmp++;
      if (ir[k] !== 1'b1 || ov[k] !== 1'b0) begin
        nbad++;
        $display("FAIL post_rst s%0d: got rdy=%b vld=%b want 1 0",
                 k + 2, ir[k], ov[k]);
      end
    end
  endtask

  task automatic test_fwd();
    logic [3:0] q[$];
    int         tq[$];
    logic       exp_v;
    for (int c = 0; c < 22; c++) begin
      drive(c < 16, 4'(c), 1'b0, 1'b1);
      @(negedge clk);
      exp_v = (q.size() > 0) ? (tq[0] + 3 == c) : 1'b0;
      for (int k = 0; k < 3; k++) begin
        ncmp++;
        if (ov[k] !== exp_v) begin
          nbad++;
          $display("FAIL fwd_valid s%0d c%0d: got %b want %b",
                   k + 2, c, ov[k], exp_v);
        end
        if (exp_v) begin
          ncmp++;
          if (got[k] !== q[0]) begin
            nbad++;
            $display("FAIL fwd_data s%0d c%0d: got %h want %h",
                     k + 2, c, got[k], q[0]);
          end
        end
      end
      if (exp_v) begin
        void'(q.pop_front());
        void'(tq.pop_front());
      end
      if (in_valid && ir[0]) begin
        q.push_back(SBOX[c]);
        tq.push_back(c);
      end
    end
    ncmp++;
    if (q.size() != 0) begin
      nbad++;
      $display("FAIL fwd_drain: got %0d left want 0", q.size());
    end
  endtask

  task automatic test_inv();
    logic [3:0] q[$];
    int         tq[$];
    logic       exp_v;
    logic [3:0] x;
    for (int c = 0; c < 38; c++) begin
      x = 4'(c >> 1);
      drive(c < 32, x, c[0], 1'b1);
      @(negedge clk);
      exp_v = (q.size() > 0) ? (tq[0] + 3 == c) : 1'b0;
      for (int k = 0; k < 3; k++) begin
        ncmp++;
        if (ov[k] !== exp_v) begin
          nbad++;
          $display("FAIL inv_valid s%0d c%0d: got %b want %b",
                   k + 2, c, ov[k], exp_v);
        end
        if (exp_v) begin
          ncmp++;
          if (got[k] !== q[0]) begin
            nbad++;
            $display("FAIL inv_data s%0d c%0d: got %h want %h",
                     k + 2, c, got[k], q[0]);
          end
        end
      end
      if (exp_v) begin
        void'(q.pop_front());
        void'(tq.pop_front());
      end
      if (in_valid && ir[0]) begin
        q.push_back(c[0] ? SINV[x] : SBOX[x]);
        tq.push_back(c);
      end
    end
    ncmp++;
    if (q.size() != 0) begin
      nbad++;
      $display("FAIL inv_drain: got %0d left want 0", q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [3:0]  q[$];
    logic [35:0] prev_o;
    logic        stall;
    int          idx = 0;
    int          nout = 0;
    prev_o = '0;
    for (int c = 0; c < 20; c++) begin
      stall = (c >= 5 && c <= 8);
      drive(idx < 8, VALS[idx & 7], 1'b0, !stall);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        ncmp++;
        if (ir[k] !== !stall) begin
          nbad++;
          $display("FAIL bp_ready s%0d c%0d: got %b want %b",
                   k + 2, c, ir[k], !stall);
        end
      end
      if (c >= 6 && c <= 9) begin
        ncmp++;
        if (all_o !== prev_o) begin
          nbad++;
          $display("FAIL bp_stable c%0d: got %h want %h", c, all_o, prev_o);
        end
      end
      if (ov[0] && out_ready) begin
        ncmp++;
        if (q.size() == 0) begin
          nbad++;
          $display("FAIL bp_extra c%0d: got output want none", c);
        end else begin
          for (int k = 0; k < 3; k++) begin
            ncmp++;
            if (got[k] !== q[0]) begin
              nbad++;
              $display("FAIL bp_data s%0d c%0d: got %h want %h",
                       k + 2, c, got[k], q[0]);
            end
          end
          void'(q.pop_front());
        end
        nout++;
      end
      if (in_valid && ir[0]) begin
        q.push_back(SBOX[VALS[idx]]);
        idx++;
      end
      prev_o = all_o;
    end
    ncmp++;
    if (nout != 8 || idx != 8) begin
      nbad++;
      $display("FAIL bp_count: got out=%0d in=%0d want 8 8", nout, idx);
    end
  endtask

  task automatic test_reset_mid();
    logic exp_v;
    for (int c = 0; c < 4; c++) begin
      drive(c < 3, 4'hA + 4'(c), 1'b0, 1'b1);
      @(negedge clk);
    end
    ncmp++;
    if (ov[0] !== 1'b1) begin
      nbad++;
      $display("FAIL mid_pre: got vld=%b want 1", ov[0]);
    end
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      ncmp++;
      if (ov[k] !== 1'b0) begin
        nbad++;
        $display("FAIL mid_rst_valid s%0d: got %b want 0", k + 2, ov[k]);
      end
    end
    ncmp++;
    if (all_o !== 36'h0) begin
      nbad++;
      $display("FAIL mid_rst_shares: got %h want 0", all_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 7; c++) begin
      drive(c == 0, 4'h6, 1'b0, 1'b1);
      @(negedge clk);
      exp_v = (c == 3);
      for (int k = 0; k < 3; k++) begin
        ncmp++;
        if (ov[k] !== exp_v || (exp_v && got[k] !== 4'h8)) begin
          nbad++;
          $display("FAIL mid_after s%0d c%0d: got vld=%b d=%h want %b 8",
                   k + 2, c, ov[k], got[k], exp_v);
        end
      end
    end
  endtask

  task automatic test_rnd();
    logic [1:0]  e_rm  [8] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1};
    logic [11:0] e_m   [8] = '{12'h5A3, 12'h5A3, 12'h5A3, 12'h5A3,
                               12'h000, 12'h333, 12'h999, 12'hFFF};
    logic [3:0]  e_x   [8] = '{4'h5, 4'h5, 4'h1, 4'h1, 4'h5, 4'h5, 4'h5, 4'h5};
    logic        e_inv [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0]  e_exp [8] = '{4'h1, 4'h1, 4'h5, 4'h5, 4'h1, 4'h1, 4'h1, 4'h1};
    logic [35:0] outs [8];
    int          ndiff = 0;
    use_fix = 1'b1;
    for (int e = 0; e < 8; e++) begin
      rmode = e_rm[e];
      fix_m = e_m[e];
      outs[e] = '0;
      for (int c = 0; c < 5; c++) begin
        drive(c == 0, e_x[e], e_inv[e], 1'b1);
        @(negedge clk);
        if (c == 3) begin
          outs[e] = all_o;
          for (int k = 0; k < 3; k++) begin
            ncmp++;
            if (ov[k] !== 1'b1 || got[k] !== e_exp[e]) begin
              nbad++;
              $display("FAIL rnd_data s%0d e%0d: got vld=%b d=%h want 1 %h",
                       k + 2, e, ov[k], got[k], e_exp[e]);
            end
          end
        end
      end
    end
    for (int e = 5; e < 8; e++)
      if (outs[e] !== outs[4]) ndiff++;
    ncmp++;
    if (ndiff == 0) begin
      nbad++;
      $display("FAIL rnd_split: got identical shares for all splits want differing");
    end
    use_fix = 1'b0;
    rmode   = 2'd0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_inv    = 1'b0;
    out_ready = 1'b1;
    in2       = '0;
    in3       = '0;
    in4       = '0;
    rnd       = '0;
    use_fix   = 1'b0;
    fix_m     = '0;
    rmode     = 2'd0;
    test_reset();
    test_fwd();
    test_inv();
    test_backpressure();
    test_reset_mid();
    test_rnd();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
